// File: rtl/csr_timer.sv
// Constant timer (TID/TCFG/TVAL/TICLR) and free-running stable counter sitting beside the CSR file.
// Shares the CSR write port and drives the registered timer interrupt level.
module csr_timer #(
    parameter int unsigned TIMER_N = 12,
    parameter int unsigned CNT_W   = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       we,
    input  logic [13:0]      waddr,
    input  logic [31:0]      wdata,
    input  logic [31:0]      rj_value,
    input  logic [13:0]      raddr,
    output logic [31:0]      rdata,
    output logic             rhit,
    output logic             timer_int,
    output logic [CNT_W-1:0] stable_cnt,
    output logic [31:0]      tid
);

    localparam logic [13:0] AddrTid   = 14'h40;
    localparam logic [13:0] AddrTcfg  = 14'h41;
    localparam logic [13:0] AddrTval  = 14'h42;
    localparam logic [13:0] AddrTiclr = 14'h44;

    logic [TIMER_N-1:0] tcfg_q, tcfg_d;
    logic [TIMER_N-1:0] tval_q, tval_d;
    logic [31:0]        tid_q, tid_d;
    logic               int_q, int_d;
    logic [CNT_W-1:0]   cnt_q;

    logic [31:0]        old_val, eff;
    logic               tcfg_wr, tid_wr, ticlr_wr, expire;
    logic               en, periodic;

    assign en       = tcfg_q[0];
    assign periodic = tcfg_q[1];

    // Masked writes merge into the addressed register's current value; TICLR reads as 0.
    always_comb begin
        old_val = '0;
        unique case (waddr)
            AddrTid:  old_val = tid_q;
            AddrTcfg: old_val = 32'(tcfg_q);
            default:  old_val = '0;
        endcase
        eff = we[0] ? wdata : ((old_val & ~rj_value) | (wdata & rj_value));
    end

    assign tid_wr   = (|we) && (waddr == AddrTid);
    assign tcfg_wr  = (|we) && (waddr == AddrTcfg);
    assign ticlr_wr = (|we) && (waddr == AddrTiclr) && eff[0];
    // A TCFG write on the same edge suppresses the expiry.
    assign expire   = !tcfg_wr && en && (tval_q == TIMER_N'(1));

    always_comb begin
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        tid_d  = tid_q;
        int_d  = int_q;
        if (tid_wr) begin
            tid_d = eff;
        end
        if (tcfg_wr) begin
            tcfg_d = eff[TIMER_N-1:0];
            tval_d = {eff[TIMER_N-1:2], 2'b00};
        end else if (en) begin
            if (tval_q != '0) begin
                tval_d = tval_q - TIMER_N'(1);
            end else if (periodic) begin
                tval_d = {tcfg_q[TIMER_N-1:2], 2'b00};
            end
        end
        if (expire) begin
            int_d = 1'b1;
        end else if (ticlr_wr) begin
            int_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcfg_q <= '0;
            tval_q <= '0;
            tid_q  <= '0;
            int_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            tid_q  <= tid_d;
            int_q  <= int_d;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        rdata = '0;
        rhit  = 1'b1;
        unique case (raddr)
            AddrTid:   rdata = tid_q;
            AddrTcfg:  rdata = 32'(tcfg_q);
            AddrTval:  rdata = 32'(tval_q);
            AddrTiclr: rdata = '0;
            default:   rhit  = 1'b0;
        endcase
    end

    assign timer_int  = int_q;
    assign stable_cnt = cnt_q;
    assign tid        = tid_q;

endmodule

// File: tb/tb_csr_timer.sv
// Directed self-checking bench for csr_timer: one-shot, periodic, collisions, masked write,
// async reset and stable counter / TID.
module tb_csr_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  we;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic [31:0] rj_value;
    logic [13:0] raddr;
    logic [31:0] rdata;
    logic        rhit;
    logic        timer_int;
    logic [63:0] stable_cnt;
    logic [31:0] tid;

    int n_checks = 0;
    int n_fail   = 0;

    csr_timer #(
        .TIMER_N(12),
        .CNT_W  (64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .rj_value  (rj_value),
        .raddr     (raddr),
        .rdata     (rdata),
        .rhit      (rhit),
        .timer_int (timer_int),
        .stable_cnt(stable_cnt),
        .tid       (tid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the n-th rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        chk(tag, 64'(rdata), 64'(exp));
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [1:0] mode,
                      input logic [31:0] mask);
        we       = mode;
        waddr    = a;
        wdata    = d;
        rj_value = mask;
        tick(1);
        we       = 2'b00;
    endtask

    initial begin
        reset    = 1'b1;
        we       = 2'b00;
        waddr    = '0;
        wdata    = '0;
        rj_value = '0;
        raddr    = '0;
        tick(2);
        chk("rst_int", 64'(timer_int), 64'd0);
        chk("rst_cnt", stable_cnt, 64'd0);
        chk("rst_tid", 64'(tid), 64'd0);
        rd("rst_tcfg", 14'h41, 32'd0);
        rd("rst_tval", 14'h42, 32'd0);

        // Stable counter and TID
        reset = 1'b0;
        tick(5);
        chk("cnt_5", stable_cnt, 64'd5);
        wr(14'h40, 32'hDEADBEEF, 2'b01, 32'd0);
        chk("tid_val", 64'(tid), 64'hDEADBEEF);
        rd("tid_rd", 14'h40, 32'hDEADBEEF);
        chk("tid_rhit", 64'(rhit), 64'd1);
        rd("bad_rd", 14'h05, 32'd0);
        chk("bad_rhit", 64'(rhit), 64'd0);
        rd("ticlr_rd", 14'h44, 32'd0);
        chk("ticlr_rhit", 64'(rhit), 64'd1);

        // One-shot: InitVal=4, En=1
        wr(14'h41, 32'h11, 2'b01, 32'd0);
        rd("os_tcfg", 14'h41, 32'h11);
        rd("os_tval16", 14'h42, 32'd16);
        tick(15);
        rd("os_tval1", 14'h42, 32'd1);
        chk("os_int_pre", 64'(timer_int), 64'd0);
        tick(1);
        rd("os_tval0", 14'h42, 32'd0);
        chk("os_int_set", 64'(timer_int), 64'd1);
        tick(3);
        rd("os_hold", 14'h42, 32'd0);
        chk("os_int_hold", 64'(timer_int), 64'd1);
        wr(14'h44, 32'd2, 2'b01, 32'd0);
        chk("ticlr_bit0_zero", 64'(timer_int), 64'd1);
        wr(14'h44, 32'd1, 2'b01, 32'd0);
        chk("os_int_clr", 64'(timer_int), 64'd0);

        // Periodic: InitVal=2, Per=1, En=1
        wr(14'h41, 32'h0B, 2'b01, 32'd0);
        rd("per_tval8", 14'h42, 32'd8);
        tick(8);
        rd("per_tval0", 14'h42, 32'd0);
        chk("per_int1", 64'(timer_int), 64'd1);
        tick(1);
        rd("per_reload", 14'h42, 32'd8);
        chk("per_reload_int", 64'(timer_int), 64'd1);
        wr(14'h44, 32'd1, 2'b01, 32'd0);
        rd("per_tval7", 14'h42, 32'd7);
        chk("per_clr", 64'(timer_int), 64'd0);
        tick(7);
        rd("per_tval0b", 14'h42, 32'd0);
        chk("per_int2", 64'(timer_int), 64'd1);

        // Collision: TICLR on the expiry edge, set wins
        wr(14'h44, 32'd1, 2'b01, 32'd0);
        chk("col_pre_clr", 64'(timer_int), 64'd0);
        tick(7);
        rd("col_tval1", 14'h42, 32'd1);
        wr(14'h44, 32'd1, 2'b01, 32'd0);
        rd("col_tval0", 14'h42, 32'd0);
        chk("col_set_wins", 64'(timer_int), 64'd1);

        // Collision: TCFG write on the expiry edge suppresses it
        wr(14'h44, 32'd1, 2'b01, 32'd0);
        chk("col2_clr", 64'(timer_int), 64'd0);
        tick(7);
        rd("col2_tval1", 14'h42, 32'd1);
        wr(14'h41, 32'h0B, 2'b01, 32'd0);
        rd("col2_reload", 14'h42, 32'd8);
        chk("col2_no_int", 64'(timer_int), 64'd0);

        // Masked write clears En: TCFG 0x0B -> 0x0A, TVAL 8 frozen
        wr(14'h41, 32'd0, 2'b10, 32'd1);
        for (int i = 0; i < 20; i++) begin
            rd("mask_tcfg", 14'h41, 32'h0A);
            rd("mask_tval", 14'h42, 32'd8);
            tick(1);
        end
        wr(14'h42, 32'd3, 2'b01, 32'd0);
        rd("tval_ro", 14'h42, 32'd8);

        // Async reset mid-count with interrupt pending
        wr(14'h41, 32'h0B, 2'b01, 32'd0);
        tick(8);
        chk("ar_int_pre", 64'(timer_int), 64'd1);
        tick(3);
        rd("ar_tval6", 14'h42, 32'd6);
        reset = 1'b1;
        #1;
        chk("ar_int", 64'(timer_int), 64'd0);
        chk("ar_cnt", stable_cnt, 64'd0);
        rd("ar_tcfg", 14'h41, 32'd0);
        rd("ar_tval", 14'h42, 32'd0);
        reset = 1'b0;
        tick(3);
        rd("ar_idle_tval", 14'h42, 32'd0);
        chk("ar_cnt3", stable_cnt, 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
